// File: rtl/sym_upsampler.sv
// 4-ASK symbol upsampler: buffers Gray-coded symbols in a small FIFO, maps
// each popped symbol to a signed s1.17 level on the symbol strobe and
// zero-stuffs by 4 on the intervening sample strobes.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no symbol emitted yet; empty FIFO at a symbol strobe is benign
//   RUN   | streaming; empty FIFO at a symbol strobe flags underflow
module sym_upsampler #(
   parameter int DW      = 18,
   parameter int DEPTH   = 4,
   parameter int LVL_OUT = 98304,
   parameter int LVL_IN  = 32768
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sam_clk_en,
   input  logic                      sym_clk_en,
   input  logic [1:0]                in_sym,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic signed [DW-1:0]      sam_out,
   output logic                      sam_valid,
   output logic [1:0]                sym_phase,
   output logic [$clog2(DEPTH):0]    fill,
   output logic                      underflow,
   output logic                      align_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic signed [DW-1:0] POS_OUT = DW'(LVL_OUT);
   localparam logic signed [DW-1:0] POS_IN  = DW'(LVL_IN);
   localparam logic signed [DW-1:0] NEG_OUT = -POS_OUT;
   localparam logic signed [DW-1:0] NEG_IN  = -POS_IN;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state, state_nxt;
   logic [1:0]            mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  push, pop, empty;
   logic signed [DW-1:0]  sam_nxt;
   logic                  valid_nxt, under_nxt, align_nxt;
   logic [1:0]            phase_nxt;

   function automatic logic signed [DW-1:0] sym_level(input logic [1:0] s);
      case (s)
         2'b00:   return NEG_OUT;
         2'b01:   return NEG_IN;
         2'b11:   return POS_IN;
         default: return POS_OUT;
      endcase
   endfunction

   assign in_ready = (fill != FULL);
   assign empty    = (fill == '0);
   assign push     = in_valid && in_ready;

   // FIFO storage; contents need no reset, pointers and fill define validity
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_sym;
   end

   // FIFO pointers and occupancy; a pop never makes room for a same-cycle push
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state, pop decision and next output values
   always_comb begin
      state_nxt = state;
      sam_nxt   = sam_out;
      valid_nxt = 1'b0;
      phase_nxt = sym_phase;
      under_nxt = underflow;
      align_nxt = align_err;
      pop       = 1'b0;

      // a symbol strobe off the sample grid is ignored apart from the flag
      if (sym_clk_en && !sam_clk_en) align_nxt = 1'b1;

      if (sam_clk_en) begin
         valid_nxt = 1'b1;
         sam_nxt   = '0;
         phase_nxt = sym_phase + 2'd1;
         if (sym_clk_en) begin
            phase_nxt = 2'd0;
            case (state)
               IDLE: begin
                  if (!empty) begin
                     pop       = 1'b1;
                     sam_nxt   = sym_level(mem[rd_ptr]);
                     state_nxt = RUN;
                  end
               end
               RUN: begin
                  if (!empty) begin
                     pop     = 1'b1;
                     sam_nxt = sym_level(mem[rd_ptr]);
                  end else begin
                     under_nxt = 1'b1;
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   // registered sample outputs and sticky status flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sam_out   <= '0;
         sam_valid <= 1'b0;
         sym_phase <= 2'd0;
         underflow <= 1'b0;
         align_err <= 1'b0;
      end else begin
         sam_out   <= sam_nxt;
         sam_valid <= valid_nxt;
         sym_phase <= phase_nxt;
         underflow <= under_nxt;
         align_err <= align_nxt;
      end
   end

endmodule

// File: tb/tb_sym_upsampler.sv
// Bench for sym_upsampler: a behavioural FIFO/level model predicts each
// output sample into a scoreboard queue when strobes are driven; entries
// are popped and compared when the DUT raises sam_valid.
module tb_sym_upsampler;

   localparam int DEPTH = 4;

   logic              clk;
   logic              reset;
   logic              sam_clk_en;
   logic              sym_clk_en;
   logic [1:0]        in_sym;
   logic              in_valid;
   logic              in_ready;
   logic signed [17:0] sam_out;
   logic              sam_valid;
   logic [1:0]        sym_phase;
   logic [2:0]        fill;
   logic              underflow;
   logic              align_err;

   sym_upsampler #(.DW(18), .DEPTH(DEPTH), .LVL_OUT(98304), .LVL_IN(32768)) dut (
      .clk        (clk),
      .reset      (reset),
      .sam_clk_en (sam_clk_en),
      .sym_clk_en (sym_clk_en),
      .in_sym     (in_sym),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sam_out    (sam_out),
      .sam_valid  (sam_valid),
      .sym_phase  (sym_phase),
      .fill       (fill),
      .underflow  (underflow),
      .align_err  (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int smp;
      int ph;
   } exp_t;

   int   n_vec;
   int   n_err;
   int   cnt;
   exp_t exp_q[$];
   int   m_q[$];
   bit   m_run;
   bit   m_under;
   bit   m_align;
   int   m_phase;
   int   m_last;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int level(input int s);
      case (s)
         0:       return -98304;
         1:       return -32768;
         3:       return 32768;
         default: return 98304;
      endcase
   endfunction

   task automatic model_clear();
      m_q.delete();
      exp_q.delete();
      m_run   = 0;
      m_under = 0;
      m_align = 0;
      m_phase = 0;
      m_last  = 0;
   endtask

   // one clock: drive inputs, predict, clock, compare
   task automatic step(input bit sam, input bit sym, input bit vld, input logic [1:0] s);
      bit   push;
      exp_t e;
      sam_clk_en = sam;
      sym_clk_en = sym;
      in_valid   = vld;
      in_sym     = s;
      #1;
      check_val("in_ready", int'(in_ready), int'(m_q.size() != DEPTH));
      push = vld && (m_q.size() != DEPTH);
      if (sam && sym) begin
         if (m_q.size() != 0) begin
            e.smp = level(m_q.pop_front());
            m_run = 1;
         end else begin
            e.smp = 0;
            if (m_run) m_under = 1;
         end
         e.ph = 0;
         exp_q.push_back(e);
      end else if (sam) begin
         e.smp = 0;
         e.ph  = (m_phase + 1) % 4;
         exp_q.push_back(e);
      end else if (sym) begin
         m_align = 1;
      end
      if (push) m_q.push_back(int'(s));
      @(posedge clk);
      #1;
      sam_clk_en = 1'b0;
      sym_clk_en = 1'b0;
      in_valid   = 1'b0;
      check_val("sam_valid", int'(sam_valid), int'(exp_q.size() != 0));
      if (sam_valid && exp_q.size() != 0) begin
         e       = exp_q.pop_front();
         m_last  = e.smp;
         m_phase = e.ph;
      end
      check_val("sam_out", int'(sam_out), m_last);
      check_val("sym_phase", int'(sym_phase), m_phase);
      check_val("fill", int'(fill), m_q.size());
      check_val("underflow", int'(underflow), int'(m_under));
      check_val("align_err", int'(align_err), int'(m_align));
   endtask

   task automatic run_clks(input int n);
      for (int i = 0; i < n; i++) begin
         step(cnt % 4 == 0, cnt % 16 == 0, 1'b0, 2'b00);
         cnt++;
      end
   endtask

   task automatic push_sym(input logic [1:0] s);
      step(1'b0, 1'b0, 1'b1, s);
   endtask

   // asynchronous reset asserted away from the clock edge; inputs are
   // deliberately active during reset to show they are ignored
   task automatic apply_reset();
      reset = 1'b0;
      #1;
      check_val("rst_sam_out", int'(sam_out), 0);
      check_val("rst_sam_valid", int'(sam_valid), 0);
      check_val("rst_sym_phase", int'(sym_phase), 0);
      check_val("rst_fill", int'(fill), 0);
      check_val("rst_underflow", int'(underflow), 0);
      check_val("rst_align_err", int'(align_err), 0);
      check_val("rst_in_ready", int'(in_ready), 1);
      in_valid   = 1'b1;
      in_sym     = 2'b10;
      sam_clk_en = 1'b1;
      sym_clk_en = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_hold_fill", int'(fill), 0);
      check_val("rst_hold_valid", int'(sam_valid), 0);
      in_valid   = 1'b0;
      sam_clk_en = 1'b0;
      sym_clk_en = 1'b0;
      reset      = 1'b1;
      model_clear();
      cnt = 0;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      cnt        = 0;
      reset      = 1'b1;
      sam_clk_en = 1'b0;
      sym_clk_en = 1'b0;
      in_valid   = 1'b0;
      in_sym     = 2'b00;
      model_clear();
      #2;
      apply_reset();

      // empty FIFO from reset: three symbol periods in IDLE, no underflow
      run_clks(48);
      check_val("idle_no_underflow", int'(underflow), 0);

      // four symbols covering the whole Gray map
      push_sym(2'b00);
      push_sym(2'b01);
      push_sym(2'b11);
      push_sym(2'b10);
      check_val("map_fill4", int'(fill), 4);
      cnt = 0;
      run_clks(64);

      // one more symbol then two periods: second symbol strobe underflows
      push_sym(2'b11);
      run_clks(32);
      check_val("underflow_set", int'(underflow), 1);
      run_clks(8);
      check_val("underflow_sticky", int'(underflow), 1);

      // symbol strobe off the sample grid
      step(1'b0, 1'b1, 1'b0, 2'b00);
      check_val("align_err_set", int'(align_err), 1);
      step(1'b1, 1'b0, 1'b0, 2'b00);
      step(1'b0, 1'b0, 1'b0, 2'b00);
      check_val("align_err_sticky", int'(align_err), 1);

      // full FIFO back-pressure, pop with in_valid held high
      apply_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 2'(i));
      check_val("full_fill", int'(fill), 4);
      check_val("full_ready", int'(in_ready), 0);
      step(1'b1, 1'b1, 1'b1, 2'b01);
      check_val("full_pop_fill", int'(fill), 3);
      step(1'b0, 1'b0, 1'b1, 2'b01);
      check_val("full_refill", int'(fill), 4);

      // empty FIFO in RUN with push on the same clock as the symbol strobe
      apply_reset();
      push_sym(2'b01);
      step(1'b1, 1'b1, 1'b0, 2'b00);
      step(1'b1, 1'b0, 1'b0, 2'b00);
      step(1'b1, 1'b1, 1'b1, 2'b10);
      check_val("nobypass_out", int'(sam_out), 0);
      check_val("nobypass_underflow", int'(underflow), 1);
      step(1'b1, 1'b1, 1'b0, 2'b00);
      check_val("nobypass_level", int'(sam_out), 98304);

      // reset mid-run with three symbols buffered
      apply_reset();
      for (int i = 0; i < 4; i++) push_sym(2'b10);
      step(1'b1, 1'b1, 1'b0, 2'b00);
      step(1'b1, 1'b0, 1'b0, 2'b00);
      check_val("midrst_fill3", int'(fill), 3);
      apply_reset();
      check_val("midrst_ready", int'(in_ready), 1);
      run_clks(20);
      check_val("midrst_fill0", int'(fill), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
